// File: rtl/uart_tx_serializer_pkg.sv
// Shared definitions for the UART serializer stages: state encodings,
// parity mode constants and the default divider width.
package uart_tx_serializer_pkg;

    localparam int UART_CLOCK_DIV_WIDTH = 16;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period divider: loads a period value and counts down to zero.
// tick is high in the last cycle of each bit period.
module uart_bit_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tick
);

    logic [WIDTH-1:0] count;

    // Reload on request, otherwise count down and hold at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - WIDTH'(1);
    end

    assign tick = (count == '0);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops words from the TX FIFO and shifts them out
// as start / data (LSB first) / optional parity / 1-2 stop bit frames.
module uart_tx_serializer
    import uart_tx_serializer_pkg::*;
#(
    parameter int WORD_SIZE       = 8,
    parameter int CLOCK_DIV_WIDTH = UART_CLOCK_DIV_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [CLOCK_DIV_WIDTH-1:0] clockScale,
    input  logic                       parityEnable,
    input  logic                       parityOdd,
    input  logic                       twoStopBits,
    input  logic [WORD_SIZE-1:0]       fifo_dataIn,
    input  logic                       fifo_isData,
    output logic                       fifo_oe,
    output logic                       tx,
    output logic                       busy,
    output logic                       frameDone
);

    localparam int CW = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;

    tx_state_e                  state, state_n;
    logic [WORD_SIZE-1:0]       shift, shift_n;
    logic [CW-1:0]              bit_cnt, bit_cnt_n;
    logic [CLOCK_DIV_WIDTH-1:0] scale_q, scale_n;
    logic                       par_en_q, par_en_n;
    logic                       two_stop_q, two_stop_n;
    logic                       par_bit_q, par_bit_n;
    logic                       tx_n, busy_n, oe_n, done_n;
    logic                       tick, t_load;
    logic [CLOCK_DIV_WIDTH-1:0] t_val;
    logic                       start_frame;

    assign start_frame = enable && fifo_isData;

    uart_bit_timer #(.WIDTH(CLOCK_DIV_WIDTH)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (t_load),
        .load_val (t_val),
        .tick     (tick)
    );

    // State and datapath registers; tx idles high so reset drives it to 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            shift      <= '0;
            bit_cnt    <= '0;
            scale_q    <= '0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            par_bit_q  <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            fifo_oe    <= 1'b0;
            frameDone  <= 1'b0;
        end else begin
            state      <= state_n;
            shift      <= shift_n;
            bit_cnt    <= bit_cnt_n;
            scale_q    <= scale_n;
            par_en_q   <= par_en_n;
            two_stop_q <= two_stop_n;
            par_bit_q  <= par_bit_n;
            tx         <= tx_n;
            busy       <= busy_n;
            fifo_oe    <= oe_n;
            frameDone  <= done_n;
        end
    end

    // Next-state and next-output logic; a frame load is shared by IDLE and
    // the end of STOP so back-to-back frames have no idle gap.
    always_comb begin
        state_n    = state;
        shift_n    = shift;
        bit_cnt_n  = bit_cnt;
        scale_n    = scale_q;
        par_en_n   = par_en_q;
        two_stop_n = two_stop_q;
        par_bit_n  = par_bit_q;
        tx_n       = tx;
        busy_n     = busy;
        oe_n       = 1'b0;
        done_n     = 1'b0;
        t_load     = 1'b0;
        t_val      = scale_q;

        case (state)
            ST_IDLE: begin
                tx_n = 1'b1;
            end
            ST_START: begin
                if (tick) begin
                    t_load    = 1'b1;
                    tx_n      = shift[0];
                    shift_n   = shift >> 1;
                    bit_cnt_n = '0;
                    state_n   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    t_load = 1'b1;
                    if (bit_cnt == CW'(WORD_SIZE - 1)) begin
                        bit_cnt_n = '0;
                        if (par_en_q) begin
                            tx_n    = par_bit_q;
                            state_n = ST_PARITY;
                        end else begin
                            tx_n    = 1'b1;
                            state_n = ST_STOP;
                        end
                    end else begin
                        tx_n      = shift[0];
                        shift_n   = shift >> 1;
                        bit_cnt_n = bit_cnt + CW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    t_load    = 1'b1;
                    tx_n      = 1'b1;
                    bit_cnt_n = '0;
                    state_n   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (two_stop_q && bit_cnt == '0) begin
                        t_load    = 1'b1;
                        bit_cnt_n = CW'(1);
                    end else begin
                        done_n  = 1'b1;
                        tx_n    = 1'b1;
                        busy_n  = 1'b0;
                        state_n = ST_IDLE;
                    end
                end
            end
            default: begin
                tx_n    = 1'b1;
                busy_n  = 1'b0;
                state_n = ST_IDLE;
            end
        endcase

        // Frame load: snapshot word and config so later CSR writes wait for the next frame.
        if ((state == ST_IDLE || (state == ST_STOP && state_n == ST_IDLE)) && start_frame) begin
            shift_n    = fifo_dataIn;
            par_en_n   = parityEnable;
            two_stop_n = twoStopBits;
            par_bit_n  = (^fifo_dataIn) ^ (parityOdd == PARITY_ODD);
            scale_n    = clockScale;
            oe_n       = 1'b1;
            busy_n     = 1'b1;
            tx_n       = 1'b0;
            bit_cnt_n  = '0;
            state_n    = ST_START;
            t_load     = 1'b1;
            t_val      = clockScale;
        end
    end

endmodule
